// File: rtl/despejo_de_registradores_pkg.sv
// Shared types and constants for the register-file dump transmitter.
package pkg_despejo;

  typedef enum logic [2:0] {
    OCIOSO,
    CABECALHO,
    BUSCA,
    ENVIO,
    FIM
  } estado_t;

  localparam logic [7:0] CABECALHO_BYTE      = 8'hA5;
  localparam int         NUM_REGS            = 32;
  localparam int         CLKS_PER_BIT_PADRAO = 434;

  // Byte i of a 32-bit word, i=3 being the most significant.
  function automatic logic [7:0] byte_de(input logic [31:0] w, input logic [1:0] i);
    return w[{i, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/despejo_de_registradores_if.sv
// Signals between the dump transmitter and the register bank visualization port / host link.
interface despejo_de_registradores_if;
  import pkg_despejo::*;

  logic                        start;
  logic [$clog2(NUM_REGS)-1:0] end_reg_v;
  logic [31:0]                 reg_v;
  logic                        tx;
  logic                        busy;
  logic                        done;

  modport master (output start, reg_v, input end_reg_v, tx, busy, done);
  modport slave  (input start, reg_v, output end_reg_v, tx, busy, done);

endinterface

// File: rtl/despejo_de_registradores_uart_tx.sv
// 8N1 byte transmitter; pronto is also high in the final stop-bit cycle so bytes chain with no gap.
module uart_tx_byte
  import pkg_despejo::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] dado,
  input  logic       valido,
  output logic       tx,
  output logic       pronto
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] r_baud;
  logic [3:0]    r_bit;
  logic [9:0]    r_quadro;
  logic          r_ativo;
  logic          w_fim_bit;
  logic          w_aceita;

  assign w_fim_bit = (r_baud == CW'(CLKS_PER_BIT - 1));
  assign pronto    = !r_ativo || (w_fim_bit && (r_bit == 4'd9));
  assign w_aceita  = valido && pronto;
  assign tx        = r_ativo ? r_quadro[0] : 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ativo <= 1'b0;
      r_baud  <= '0;
      r_bit   <= '0;
    end else if (w_aceita) begin
      r_ativo <= 1'b1;
      r_baud  <= '0;
      r_bit   <= '0;
    end else if (r_ativo) begin
      if (w_fim_bit) begin
        r_baud <= '0;
        if (r_bit == 4'd9) r_ativo <= 1'b0;
        else               r_bit   <= r_bit + 4'd1;
      end else begin
        r_baud <= r_baud + CW'(1);
      end
    end
  end

  // Frame shifts out LSB first: start bit, 8 data bits, stop bit.
  always_ff @(posedge clock) begin
    if (w_aceita)                  r_quadro <= {1'b1, dado, 1'b0};
    else if (r_ativo && w_fim_bit) r_quadro <= {1'b1, r_quadro[9:1]};
  end

endmodule

// File: rtl/despejo_de_registradores.sv
// Walks all registers through the bank's visualization port and streams them over UART after an A5 header.
module despejo_de_registradores
  import pkg_despejo::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_PADRAO
) (
  input logic                        clock,
  input logic                        reset,
  despejo_de_registradores_if.slave  bus
);

  estado_t     r_estado, w_prox;
  logic [4:0]  r_indice, w_prox_indice;
  logic [1:0]  r_byte, w_prox_byte;
  logic [31:0] r_foto;
  logic [7:0]  w_dado;
  logic        w_valido;
  logic        w_pronto;
  logic        w_tx;

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clock  (clock),
    .reset  (reset),
    .dado   (w_dado),
    .valido (w_valido),
    .tx     (w_tx),
    .pronto (w_pronto)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= OCIOSO;
      r_indice <= '0;
      r_byte   <= '0;
    end else begin
      r_estado <= w_prox;
      r_indice <= w_prox_indice;
      r_byte   <= w_prox_byte;
    end
  end

  // r_byte names the byte currently on the wire; the MSB goes out straight from reg_v during BUSCA.
  always_comb begin
    w_prox        = r_estado;
    w_prox_indice = r_indice;
    w_prox_byte   = r_byte;
    w_dado        = CABECALHO_BYTE;
    w_valido      = 1'b0;
    case (r_estado)
      OCIOSO: begin
        if (bus.start) begin
          w_valido = 1'b1;
          w_prox   = CABECALHO;
        end
      end
      CABECALHO: begin
        if (w_pronto) w_prox = BUSCA;
      end
      BUSCA: begin
        w_valido    = 1'b1;
        w_dado      = byte_de(bus.reg_v, 2'd3);
        w_prox_byte = 2'd3;
        w_prox      = ENVIO;
      end
      ENVIO: begin
        if (w_pronto) begin
          if (r_byte != 2'd0) begin
            w_valido    = 1'b1;
            w_dado      = byte_de(r_foto, r_byte - 2'd1);
            w_prox_byte = r_byte - 2'd1;
          end else if (r_indice == 5'(NUM_REGS - 1)) begin
            w_prox_indice = '0;
            w_prox        = FIM;
          end else begin
            w_prox_indice = r_indice + 5'd1;
            w_prox        = BUSCA;
          end
        end
      end
      FIM: w_prox = OCIOSO;
      default: w_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (r_estado == BUSCA) r_foto <= bus.reg_v;
  end

  assign bus.end_reg_v = r_indice;
  assign bus.tx        = w_tx;
  assign bus.busy      = (r_estado == CABECALHO) || (r_estado == BUSCA) || (r_estado == ENVIO);
  assign bus.done      = (r_estado == FIM);

endmodule

// File: tb/tb_despejo_de_registradores.sv
// Bench for the register dump transmitter with a behavioural bank and a UART receive monitor.
module tb_despejo_de_registradores;
  localparam int CPB   = 4;
  localparam int NBITS = 10 * CPB;
  localparam int BUSY_CYCLES = 1290 * CPB + 32;

  typedef struct {
    logic [7:0] b;
    bit         ok;
    int         gap;
  } rx_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [31:0] bank [32];
  logic [7:0]  exp_q [$];
  rx_t         rx_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  despejo_de_registradores_if bus ();

  assign bus.reg_v = bank[bus.end_reg_v];

  despejo_de_registradores #(.CLKS_PER_BIT(CPB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // UART receiver: samples on the falling edge, records every sample of each frame.
  initial begin
    bit m_rx = 0;
    int m_cnt = 0;
    int m_gap = 0;
    logic [NBITS-1:0] m_s;
    rx_t r;
    forever begin
      @(negedge clock);
      if (reset) begin
        m_rx = 0;
        m_gap = 0;
      end else if (!m_rx) begin
        if (bus.tx === 1'b0) begin
          m_rx = 1; m_cnt = 1; m_s[0] = 1'b0;
        end else begin
          m_gap++;
        end
      end else begin
        m_s[m_cnt] = bus.tx;
        m_cnt++;
        if (m_cnt == NBITS) begin
          r.ok = 1;
          for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < CPB; j++)
              if (m_s[k*CPB+j] !== m_s[k*CPB+1]) r.ok = 0;
            if (k >= 1 && k <= 8) r.b[k-1] = m_s[k*CPB+1];
          end
          if (m_s[1] !== 1'b0 || m_s[9*CPB+1] !== 1'b1) r.ok = 0;
          r.gap = m_gap;
          rx_q.push_back(r);
          m_rx = 0;
          m_gap = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic init_bank();
    for (int i = 0; i < 32; i++) bank[i] = 32'h1000_0000 + i;
    bank[0]  = 32'h0;
    bank[29] = 32'h7fffeffc;
  endtask

  task automatic push_frame();
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 32; i++)
      for (int b = 3; b >= 0; b--) exp_q.push_back(bank[i][8*b +: 8]);
  endtask

  task automatic pulse_start();
    @(posedge clock); #1 bus.start = 1'b1;
    @(posedge clock); #1 bus.start = 1'b0;
  endtask

  task automatic measure_busy(output int cnt, output logic saw_done);
    cnt = 0;
    saw_done = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (!bus.busy) begin
        saw_done = bus.done;
        break;
      end
      cnt++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset();
    bit bad;
    bus.start = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if ({bus.tx, bus.busy, bus.done, bus.end_reg_v} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got tx/busy/done/addr %b/%b/%b/%0d want 1/0/0/0",
               bus.tx, bus.busy, bus.done, bus.end_reg_v);
    end
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clock); #1;
      n_checks++;
      if ({bus.tx, bus.busy, bus.done, bus.end_reg_v} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
        n_fail++;
        $display("FAIL idle_cycle_%0d: got tx/busy/done/addr %b/%b/%b/%0d want 1/0/0/0",
                 i, bus.tx, bus.busy, bus.done, bus.end_reg_v);
      end
    end
  endtask

  task automatic test_single_dump();
    int cnt;
    logic dn;
    push_frame();
    pulse_start();
    n_checks++;
    if (bus.busy !== 1'b1 || bus.tx !== 1'b0) begin
      n_fail++;
      $display("FAIL first_cycle: got busy=%b tx=%b want busy=1 tx=0", bus.busy, bus.tx);
    end
    measure_busy(cnt, dn);
    n_checks++;
    if (cnt !== BUSY_CYCLES) begin
      n_fail++;
      $display("FAIL busy_length: got %0d want %0d", cnt, BUSY_CYCLES);
    end
    n_checks++;
    if (dn !== 1'b1) begin
      n_fail++;
      $display("FAIL done_pulse: got %b want 1", dn);
    end
    @(posedge clock); #1;
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_width: got %b want 0", bus.done);
    end
    repeat (5) @(posedge clock);
  endtask

  task automatic test_snapshot();
    int cnt;
    logic dn;
    bit found = 0;
    logic [31:0] w;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 32; i++) begin
      w = (i == 6) ? 32'hCAFEF00D : bank[i];
      for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
    end
    pulse_start();
    for (int i = 0; i < 2000; i++) begin
      if (bus.end_reg_v == 5'd5) begin
        found = 1;
        break;
      end
      @(posedge clock); #1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL reach_reg5: got no fetch of reg 5 want fetch within 2000 cycles");
    end
    @(posedge clock); #1;
    bank[5] = 32'hDEADBEEF;
    bank[6] = 32'hCAFEF00D;
    measure_busy(cnt, dn);
    n_checks++;
    if (dn !== 1'b1) begin
      n_fail++;
      $display("FAIL snapshot_done: got %b want 1", dn);
    end
    repeat (5) @(posedge clock);
  endtask

  task automatic test_back_to_back();
    int cnt;
    logic dn;
    push_frame();
    push_frame();
    @(posedge clock); #1 bus.start = 1'b1;
    @(posedge clock); #1;
    measure_busy(cnt, dn);
    n_checks++;
    if (cnt !== BUSY_CYCLES || dn !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: got busy=%0d done=%b want busy=%0d done=1", cnt, dn, BUSY_CYCLES);
    end
    @(posedge clock); #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: got busy=%b done=%b want 0/0", bus.busy, bus.done);
    end
    @(posedge clock); #1;
    bus.start = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.tx !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_restart: got busy=%b tx=%b want 1/0", bus.busy, bus.tx);
    end
    cnt = 0;
    for (int i = 0; i < 20000; i++) begin
      if (!bus.busy) break;
      cnt++;
      bus.start = (cnt % 700 == 0);
      @(posedge clock); #1;
    end
    dn = bus.done;
    bus.start = 1'b0;
    n_checks++;
    if (cnt !== BUSY_CYCLES || dn !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second: got busy=%0d done=%b want busy=%0d done=1", cnt, dn, BUSY_CYCLES);
    end
    repeat (5) @(posedge clock);
  endtask

  task automatic test_reset_mid_dump();
    int cnt;
    logic dn;
    int sz_r;
    bit found = 0;
    sz_r = rx_q.size();
    pulse_start();
    for (int i = 0; i < 4000; i++) begin
      if (bus.end_reg_v == 5'd12) begin
        found = 1;
        break;
      end
      @(posedge clock); #1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL reach_reg12: got no fetch of reg 12 want fetch within 4000 cycles");
    end
    repeat (7) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    n_checks++;
    if ({bus.tx, bus.busy, bus.done, bus.end_reg_v} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL mid_reset: got tx/busy/done/addr %b/%b/%b/%0d want 1/0/0/0",
               bus.tx, bus.busy, bus.done, bus.end_reg_v);
    end
    reset = 1'b0;
    while (rx_q.size() > sz_r) void'(rx_q.pop_back());
    repeat (3) @(posedge clock);
    push_frame();
    pulse_start();
    measure_busy(cnt, dn);
    n_checks++;
    if (cnt !== BUSY_CYCLES || dn !== 1'b1) begin
      n_fail++;
      $display("FAIL after_reset: got busy=%0d done=%b want busy=%0d done=1", cnt, dn, BUSY_CYCLES);
    end
    repeat (5) @(posedge clock);
  endtask

  task automatic test_frame_stream();
    int want_gap;
    for (int n = 0; n < exp_q.size(); n++) begin
      n_checks++;
      if (n >= rx_q.size()) begin
        n_fail++;
        $display("FAIL stream_length: got %0d bytes want %0d", rx_q.size(), exp_q.size());
        break;
      end
      if (rx_q[n].b !== exp_q[n]) begin
        n_fail++;
        $display("FAIL byte_%0d: got %02h want %02h", n, rx_q[n].b, exp_q[n]);
      end
      n_checks++;
      if (rx_q[n].ok !== 1'b1) begin
        n_fail++;
        $display("FAIL bit_period_%0d: got irregular bit timing want %0d cycles per bit", n, CPB);
      end
      if (n % 129 != 0) begin
        want_gap = ((n % 129 - 1) % 4 == 0) ? 1 : 0;
        n_checks++;
        if (rx_q[n].gap !== want_gap) begin
          n_fail++;
          $display("FAIL gap_%0d: got %0d idle cycles want %0d", n, rx_q[n].gap, want_gap);
        end
      end
    end
    n_checks++;
    if (rx_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL stream_total: got %0d bytes want %0d", rx_q.size(), exp_q.size());
    end
  endtask

  initial begin
    bus.start = 1'b0;
    init_bank();
    test_reset();
    test_single_dump();
    test_snapshot();
    test_back_to_back();
    test_reset_mid_dump();
    test_frame_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/despejo_de_registradores.md
# despejo_de_registradores

Register-file dump transmitter: on a start pulse it walks all 32 registers through one visualization read port of the register bank and serializes them over an 8N1 UART line to a host PC. It is the reader/consumer end of the bank's visualization port (`end_reg_v*` address out, `reg_v*` data in). It runs beside the MIPS core without stalling it and is used for board-level debug of processor state.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200); legal range ≥ 2.

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: request a dump; sampled only while idle.
- `end_reg_v`  out  5: register address driven to the bank's visualization port.
- `reg_v`  in  32: register value for `end_reg_v`, combinational from the bank, same cycle.
- `tx`  out  1: UART serial output, idle high.
- `busy`  out  1: high from the cycle after `start` is accepted until the dump finishes.
- `done`  out  1: one-cycle pulse after the last stop bit.

## Operation
- Reset values:
  - `tx`=1, `busy`=0, `done`=0, `end_reg_v`=0.
  - FSM in OCIOSO, register index 0, byte counter 0.
- Frame on the wire:
  - Header byte 8'hA5.
  - Registers 0..31 in order, each as 4 bytes, most significant byte first.
  - Total 129 bytes.
- Each byte: start bit 0, data bits 0..7 (LSB first), stop bit 1. Every bit lasts exactly `CLKS_PER_BIT` cycles.
- FSM states:
  - OCIOSO: `tx`=1, `end_reg_v`=0. `start`=1 moves to CABECALHO.
  - CABECALHO: transmit 8'hA5, then go to BUSCA.
  - BUSCA (exactly 1 cycle): drive `end_reg_v`=index and latch `reg_v` into a 32-bit snapshot at the end of the cycle. `tx`=1. Go to ENVIO.
  - ENVIO: transmit snapshot bytes 3,2,1,0. Then:
    - if index<31: index+1, go to BUSCA;
    - if index=31: go to FIM.
  - FIM (1 cycle): `done`=1, `busy`=0, index cleared, then OCIOSO.
- Snapshot rule:
  - Each register is sampled once, in its BUSCA cycle.
  - A core write to that register while its bytes are in flight does not alter the transmitted word (no tearing).
  - Writes to registers not yet fetched are reflected in the dump. The dump is not an atomic image of the whole file.
- `start` while `busy`=1 is ignored, including during FIM. No queuing.
- `reset` asserted mid-dump: on the next edge all outputs take their reset values. A partial byte is truncated and `tx` returns high immediately. The host detects this by timeout/length.
- Index arithmetic is 5-bit, with 31 as the terminal value; no wrap to 0 occurs within a dump.

## Timing
- `start` sampled high at edge E0 (while idle): from the cycle after E0, `busy`=1 and `tx`=0 (header start bit).
- Header occupies 10·`CLKS_PER_BIT` cycles.
- Each register occupies 1 (BUSCA, `tx`=1) + 40·`CLKS_PER_BIT` cycles. Bytes within a register are back-to-back, with no idle cycles.
- Total `busy` duration: 1290·`CLKS_PER_BIT` + 32 cycles, followed by the single FIM cycle with `done`=1.
- The byte transmitter accepts the next byte in the same cycle its previous stop bit ends. The handshake adds zero cycles.

## Structure
- Shared package `pkg_despejo` holds:
  - the FSM state enum (OCIOSO, CABECALHO, BUSCA, ENVIO, FIM);
  - constant `CABECALHO_BYTE` = 8'hA5;
  - constant `NUM_REGS` = 32;
  - default `CLKS_PER_BIT`.
- One sub-module, `uart_tx_byte`:
  - inputs: `clock`, `reset`, `dado[7:0]`, `valido`;
  - outputs: `tx`, `pronto`;
  - internals: baud counter and bit counter.
- Top level: dump FSM, register index, byte counter, snapshot register.

## Test plan
Run with `CLKS_PER_BIT`=4 and a behavioural bank model preloaded with reg[i] = 32'h1000_0000 + i, reg[0] = 0, reg[29] = 32'h7fffeffc.
- Idle after reset, no start → `tx`=1, `busy`=0, `end_reg_v`=0 for 1000 cycles.
- Single `start` pulse → UART monitor decodes, in order:
  - A5;
  - 00 00 00 00;
  - 10 00 00 01 … (through reg 28);
  - 7F FF EF FC for reg 29;
  - … 10 00 00 1F.
  - `busy` high for exactly 5192 cycles, then `done` for 1 cycle.
- Bank write of reg[5] to 32'hDEADBEEF in the cycle after reg 5's BUSCA → bytes 10 00 00 05 sent. Write of reg[6] to 32'hCAFEF00D before reg 6's BUSCA → CA FE F0 0D sent.
- `start` held high for the whole dump plus 1 cycle after `done` → a second dump begins exactly one cycle after `done`. Pulses during `busy` are ignored.
- `reset` asserted mid-byte in reg 12 → next cycle `tx`=1, `busy`=0, `end_reg_v`=0. A subsequent `start` yields a complete, correct 129-byte frame.
- Bit-period check: every start, data and stop bit is exactly 4 cycles. The BUSCA idle gap is exactly 1 cycle before each register's first byte.
